// File: rtl/pulse_event_sync_pkg.sv
// pulse_event_sync_pkg
//   Shared constants and helpers for the pulse event synchronizer receiver.
//   Holds the default and legal ranges of the block parameters, and the
//   function that sizes the channel-index output.
//   Optional feature macro used by the design files: PULSE_EVENT_SYNC_OVF_EN
//   (adds sticky per-channel overflow flags).

package pulse_event_sync_pkg;

  // Default parameter values and their legal ranges
  localparam int DEF_NUM_CH      = 4;
  localparam int MIN_NUM_CH      = 1;
  localparam int MAX_NUM_CH      = 32;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;

  localparam int DEF_CNT_W       = 3;
  localparam int MIN_CNT_W       = 1;
  localparam int MAX_CNT_W       = 8;

  // Width of the channel index; a single channel still gets a 1-bit index
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/pulse_event_sync_ch.sv
// pulse_event_sync_ch
//   One receive channel: synchronizes an asynchronous toggle level, turns each
//   level change into a single-cycle event, and keeps a saturating count of
//   events not yet consumed.
//   Optional macro: PULSE_EVENT_SYNC_OVF_EN adds the o_ovf_pulse output.
//
// Ports
//   i_clk        destination clock (rising edge)
//   i_rst        synchronous active-high reset
//   i_tog        asynchronous toggle level from the source domain
//   i_dec        consumer takes one event from this channel this cycle
//   o_busy       counter is nonzero (an event is pending)
//   o_ovf_pulse  (macro only) an event was dropped because the counter was full

module pulse_event_sync_ch
  import pulse_event_sync_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tog,
  input  logic i_dec,
  output logic o_busy
`ifdef PULSE_EVENT_SYNC_OVF_EN
  ,
  output logic o_ovf_pulse
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic             hist_q;
  logic [CNT_W-1:0] cnt_q;
  logic             evt;
  logic             at_max;

  // Synchronizer chain plus a history flop one stage behind the last sync
  // stage; comparing the two exposes every level change exactly once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_tog};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt    = sync_q[SYNC_STAGES-1] ^ hist_q;
  assign at_max = (cnt_q == CNT_MAX);

  // Saturating up/down counter. An arrival and a take in the same cycle
  // cancel, so a full counter that is also being drained never drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (evt && !i_dec && !at_max) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (!evt && i_dec) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign o_busy = |cnt_q;

`ifdef PULSE_EVENT_SYNC_OVF_EN
  assign o_ovf_pulse = evt && !i_dec && at_max;
`endif

endmodule

// File: rtl/pulse_event_sync_rx.sv
// pulse_event_sync_rx
//   Receives NUM_CH asynchronous toggle channels, counts pending events per
//   channel and presents them one at a time through a valid/ready handshake,
//   choosing among busy channels in round-robin order.
//   Optional macro: PULSE_EVENT_SYNC_OVF_EN adds the sticky o_ovf flags.
//
// Ports
//   i_clk    destination clock (rising edge)
//   i_rst    synchronous active-high reset
//   i_tog    per-channel asynchronous toggle levels
//   i_ready  consumer accepts the presented event
//   o_valid  at least one channel has a pending event
//   o_ch     index of the channel whose event is presented
//   o_ovf    (macro only) sticky per-channel overflow flags

module pulse_event_sync_rx
  import pulse_event_sync_pkg::*;
#(
  parameter  int NUM_CH      = DEF_NUM_CH,
  parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter  int CNT_W       = DEF_CNT_W,
  localparam int CH_W        = ch_idx_w(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_tog,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [CH_W-1:0]   o_ch
`ifdef PULSE_EVENT_SYNC_OVF_EN
  ,
  output logic [NUM_CH-1:0] o_ovf
`endif
);

  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] dec;
  logic              accept;
`ifdef PULSE_EVENT_SYNC_OVF_EN
  logic [NUM_CH-1:0] ovf_pulse;
`endif

  // o_valid and o_ch come only from counter and pointer registers, so
  // i_ready never reaches them combinationally.
  assign o_valid = |busy;
  assign accept  = o_valid && i_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign dec[k] = accept && (o_ch == CH_W'(k));

    pulse_event_sync_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_tog      (i_tog[k]),
      .i_dec      (dec[k]),
      .o_busy     (busy[k])
`ifdef PULSE_EVENT_SYNC_OVF_EN
      ,
      .o_ovf_pulse(ovf_pulse[k])
`endif
    );
  end

  if (NUM_CH == 1) begin : g_single
    assign o_ch = '0;
  end else begin : g_rr
    logic [CH_W-1:0] rr_q;
    logic [CH_W-1:0] sel_hi;
    logic [CH_W-1:0] sel_lo;
    logic            any_hi;

    // Find the first busy channel at or above rr_q; failing that, wrap and
    // take the lowest busy channel. Scanning downwards lets the last match
    // win, which is the lowest index in each half. With nothing busy the
    // pointer itself is shown, so o_ch stays put while o_valid is low.
    always_comb begin
      sel_hi = rr_q;
      sel_lo = rr_q;
      any_hi = 1'b0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (busy[k]) begin
          sel_lo = CH_W'(k);
          if (k >= int'(rr_q)) begin
            sel_hi = CH_W'(k);
            any_hi = 1'b1;
          end
        end
      end
    end

    assign o_ch = any_hi ? sel_hi : sel_lo;

    // After each accept the search restarts just past the served channel,
    // so a busy channel cannot starve the others.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        rr_q <= '0;
      end else if (accept) begin
        rr_q <= (o_ch == CH_W'(NUM_CH - 1)) ? '0 : o_ch + CH_W'(1);
      end
    end
  end

`ifdef PULSE_EVENT_SYNC_OVF_EN
  // Overflow flags are sticky; only reset clears them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ovf <= '0;
    end else begin
      o_ovf <= o_ovf | ovf_pulse;
    end
  end
`endif

endmodule
